// File: rtl/e203_exu_rf_wbarb_if.sv
// Write-back bundle between the ALU/long-pipe requesters, the regfile write port and the forwarding view.
// slave = arbiter side, master = requester/regfile side.
interface e203_exu_rf_wbarb_if #(
   parameter int XLEN    = 32,
   parameter int RFIDX_W = 5
);
   logic               alu_wbck_valid;
   logic               alu_wbck_ready;
   logic [RFIDX_W-1:0] alu_wbck_idx;
   logic [XLEN-1:0]    alu_wbck_dat;

   logic               lgp_wbck_valid;
   logic               lgp_wbck_ready;
   logic [RFIDX_W-1:0] lgp_wbck_idx;
   logic [XLEN-1:0]    lgp_wbck_dat;

   logic               rf_wen;
   logic [RFIDX_W-1:0] rf_widx;
   logic [XLEN-1:0]    rf_wdat;

   logic               byp_valid;
   logic [RFIDX_W-1:0] byp_idx;
   logic [XLEN-1:0]    byp_dat;

   modport slave (
      input  alu_wbck_valid, alu_wbck_idx, alu_wbck_dat,
      input  lgp_wbck_valid, lgp_wbck_idx, lgp_wbck_dat,
      output alu_wbck_ready, lgp_wbck_ready,
      output rf_wen, rf_widx, rf_wdat,
      output byp_valid, byp_idx, byp_dat
   );

   modport master (
      output alu_wbck_valid, alu_wbck_idx, alu_wbck_dat,
      output lgp_wbck_valid, lgp_wbck_idx, lgp_wbck_dat,
      input  alu_wbck_ready, lgp_wbck_ready,
      input  rf_wen, rf_widx, rf_wdat,
      input  byp_valid, byp_idx, byp_dat
   );
endinterface

// File: rtl/e203_exu_rf_wbarb.sv
// Regfile write-back arbiter: long-pipe priority with ALU anti-starvation, 1-cycle registered write, readys combinational.
// Forwarding outputs are live only with E203_RF_WBARB_BYPASS_EN defined; otherwise tied to 0.
module e203_exu_rf_wbarb #(
   parameter int XLEN       = 32,
   parameter int RFIDX_W    = 5,
   parameter int STARVE_MAX = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   e203_exu_rf_wbarb_if.slave   wb
);
   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   logic               alu_gnt;
   logic               lgp_gnt;
   logic               force_alu;

   logic [2:0]         starve_cnt_q, starve_cnt_d;
   logic               rf_wen_q, rf_wen_d;
   logic [RFIDX_W-1:0] rf_widx_q, rf_widx_d;
   logic [XLEN-1:0]    rf_wdat_q, rf_wdat_d;

   // Long-pipe wins contention unless the ALU has already lost STARVE_MAX times in a row.
   assign force_alu = (starve_cnt_q == STARVE_LIM);
   assign lgp_gnt   = wb.lgp_wbck_valid & ~(wb.alu_wbck_valid & force_alu);
   assign alu_gnt   = wb.alu_wbck_valid & ~lgp_gnt;

   assign wb.alu_wbck_ready = alu_gnt;
   assign wb.lgp_wbck_ready = lgp_gnt;

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (alu_gnt) begin
         starve_cnt_d = 3'd0;
      end else if (wb.alu_wbck_valid && (starve_cnt_q < STARVE_LIM)) begin
         starve_cnt_d = starve_cnt_q + 3'd1;
      end
   end

   always_comb begin
      rf_wen_d  = 1'b0;
      rf_widx_d = rf_widx_q;
      rf_wdat_d = rf_wdat_q;
      if (lgp_gnt) begin
         rf_wen_d  = (wb.lgp_wbck_idx != '0);
         rf_widx_d = wb.lgp_wbck_idx;
         rf_wdat_d = wb.lgp_wbck_dat;
      end else if (alu_gnt) begin
         rf_wen_d  = (wb.alu_wbck_idx != '0);
         rf_widx_d = wb.alu_wbck_idx;
         rf_wdat_d = wb.alu_wbck_dat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q <= 3'd0;
         rf_wen_q     <= 1'b0;
         rf_widx_q    <= '0;
         rf_wdat_q    <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         rf_wen_q     <= rf_wen_d;
         rf_widx_q    <= rf_widx_d;
         rf_wdat_q    <= rf_wdat_d;
      end
   end

   assign wb.rf_wen  = rf_wen_q;
   assign wb.rf_widx = rf_widx_q;
   assign wb.rf_wdat = rf_wdat_q;

`ifdef E203_RF_WBARB_BYPASS_EN
   assign wb.byp_valid = rf_wen_q;
   assign wb.byp_idx   = rf_widx_q;
   assign wb.byp_dat   = rf_wdat_q;
`else
   assign wb.byp_valid = 1'b0;
   assign wb.byp_idx   = '0;
   assign wb.byp_dat   = '0;
`endif

endmodule

// File: tb/tb_e203_exu_rf_wbarb.sv
// Directed bench for the regfile write-back arbiter; forwarding expectations follow E203_RF_WBARB_BYPASS_EN.
module tb_e203_exu_rf_wbarb;
   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   e203_exu_rf_wbarb_if #(.XLEN(32), .RFIDX_W(5)) wb_if ();

   e203_exu_rf_wbarb #(.XLEN(32), .RFIDX_W(5), .STARVE_MAX(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (wb_if)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rdy(input string tag, input logic e_alu, input logic e_lgp);
      chk({tag, ".alu_ready"}, 32'(wb_if.alu_wbck_ready), 32'(e_alu));
      chk({tag, ".lgp_ready"}, 32'(wb_if.lgp_wbck_ready), 32'(e_lgp));
   endtask

   // Checks the write port and the forwarding view; idx/dat only when chk_dat is set.
   task automatic chk_wr(input string tag, input logic ewen, input logic chk_dat,
                         input logic [4:0] eidx, input logic [31:0] edat);
      logic       bv;
      logic [4:0] bi;
      logic [31:0] bd;
`ifdef E203_RF_WBARB_BYPASS_EN
      bv = ewen; bi = eidx; bd = edat;
`else
      bv = 1'b0; bi = 5'd0; bd = 32'd0;
`endif
      chk({tag, ".rf_wen"},    32'(wb_if.rf_wen),    32'(ewen));
      chk({tag, ".byp_valid"}, 32'(wb_if.byp_valid), 32'(bv));
      if (chk_dat) begin
         chk({tag, ".rf_widx"}, 32'(wb_if.rf_widx), 32'(eidx));
         chk({tag, ".rf_wdat"}, wb_if.rf_wdat,      edat);
         chk({tag, ".byp_idx"}, 32'(wb_if.byp_idx), 32'(bi));
         chk({tag, ".byp_dat"}, wb_if.byp_dat,      bd);
      end
   endtask

   task automatic drive_alu(input logic v, input logic [4:0] idx, input logic [31:0] dat);
      wb_if.alu_wbck_valid = v;
      wb_if.alu_wbck_idx   = idx;
      wb_if.alu_wbck_dat   = dat;
   endtask

   task automatic drive_lgp(input logic v, input logic [4:0] idx, input logic [31:0] dat);
      wb_if.lgp_wbck_valid = v;
      wb_if.lgp_wbck_idx   = idx;
      wb_if.lgp_wbck_dat   = dat;
   endtask

   initial begin
      rst_n = 1'b0;
      drive_alu(1'b0, 5'd0, 32'd0);
      drive_lgp(1'b0, 5'd0, 32'd0);
      #2;
      chk_wr("reset", 1'b0, 1'b1, 5'd0, 32'd0);
      chk("reset.starve", 32'(dut.starve_cnt_q), 32'd0);
      chk_rdy("reset.idle", 1'b0, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;

      // Lone ALU write.
      drive_alu(1'b1, 5'd5, 32'h1234);
      #1;
      chk_rdy("alu_lone", 1'b1, 1'b0);
      tick();
      drive_alu(1'b0, 5'd0, 32'd0);
      chk_wr("alu_lone.wr", 1'b1, 1'b1, 5'd5, 32'h1234);
      tick();
      chk_wr("alu_lone.hold", 1'b0, 1'b1, 5'd5, 32'h1234);

      // Contention: long-pipe wins, ALU starve count rises.
      drive_alu(1'b1, 5'd4, 32'hBBBB);
      drive_lgp(1'b1, 5'd3, 32'hAAAA);
      #1;
      chk_rdy("contend", 1'b0, 1'b1);
      tick();
      drive_alu(1'b0, 5'd0, 32'd0);
      drive_lgp(1'b0, 5'd0, 32'd0);
      chk_wr("contend.wr", 1'b1, 1'b1, 5'd3, 32'hAAAA);
      chk("contend.starve", 32'(dut.starve_cnt_q), 32'd1);
      tick();
      chk("idle.starve_hold", 32'(dut.starve_cnt_q), 32'd1);

      // ALU grant clears the starve count.
      drive_alu(1'b1, 5'd7, 32'h77);
      tick();
      drive_alu(1'b0, 5'd0, 32'd0);
      chk_wr("alu_clear.wr", 1'b1, 1'b1, 5'd7, 32'h77);
      chk("alu_clear.starve", 32'(dut.starve_cnt_q), 32'd0);

      // Sustained contention: ALU forced through every fourth cycle.
      for (int i = 0; i < 8; i++) begin
         logic ealu;
         ealu = (i == 3) || (i == 7);
         drive_alu(1'b1, 5'd8, 32'h100 + 32'(i));
         drive_lgp(1'b1, 5'd9, 32'h200 + 32'(i));
         #1;
         chk_rdy($sformatf("starve[%0d]", i), ealu, !ealu);
         tick();
         chk_wr($sformatf("starve[%0d].wr", i), 1'b1, 1'b1,
                ealu ? 5'd8 : 5'd9, ealu ? (32'h100 + 32'(i)) : (32'h200 + 32'(i)));
      end
      drive_alu(1'b0, 5'd0, 32'd0);
      drive_lgp(1'b0, 5'd0, 32'd0);

      // Back-to-back writes to the same register stay ordered and separate.
      drive_lgp(1'b1, 5'd12, 32'h1);
      tick();
      drive_lgp(1'b1, 5'd12, 32'h2);
      chk_wr("b2b.first", 1'b1, 1'b1, 5'd12, 32'h1);
      tick();
      drive_lgp(1'b0, 5'd0, 32'd0);
      chk_wr("b2b.second", 1'b1, 1'b1, 5'd12, 32'h2);

      // Write to x0 is accepted but never reaches the regfile.
      drive_lgp(1'b1, 5'd0, 32'hFFFF_FFFF);
      #1;
      chk_rdy("x0", 1'b0, 1'b1);
      tick();
      drive_lgp(1'b0, 5'd0, 32'd0);
      chk_wr("x0.wr", 1'b0, 1'b0, 5'd0, 32'd0);

      // Reset asserted with a write in flight.
      drive_alu(1'b1, 5'd6, 32'h66);
      tick();
      drive_alu(1'b0, 5'd0, 32'd0);
      chk_wr("rst_mid.pre", 1'b1, 1'b1, 5'd6, 32'h66);
      #2;
      rst_n = 1'b0;
      #1;
      chk_wr("rst_mid.async", 1'b0, 1'b1, 5'd0, 32'd0);
      chk("rst_mid.starve", 32'(dut.starve_cnt_q), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk_wr("rst_mid.post1", 1'b0, 1'b0, 5'd0, 32'd0);

      // Grant possible immediately after reset release.
      drive_alu(1'b1, 5'd1, 32'h11);
      #1;
      chk_rdy("post_rst", 1'b1, 1'b0);
      tick();
      drive_alu(1'b0, 5'd0, 32'd0);
      chk_wr("post_rst.wr", 1'b1, 1'b1, 5'd1, 32'h11);
      tick();
      chk_wr("post_rst.idle", 1'b0, 1'b1, 5'd1, 32'h11);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
